aud_player: RTL and testbench

Playback-side I2S serializer: fetches 16-bit samples from the shared audio SRAM and shifts them MSB-first onto the codec DAC data line, aligned to the codec-driven DACLRCK. Counterpart of the recorder in the audio path: it reads back the region the recorder filled, from address 0 through a recorded stop address. It supports start/pause/stop control plus integer fast-forward (sample skipping) and slow-motion (sample repetition). It runs on the codec bit clock and sits between the top-level control FSM, the SRAM read port, and the WM8731 DAC pins.

---
 rtl/aud_pkg.sv | 6 +
 rtl/aud_player_if.sv | 21 ++
 rtl/i2s_tx_serializer.sv | 53 +++++
 rtl/aud_player.sv | 102 ++++++++++
 tb/tb_aud_player.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/aud_pkg.sv
// aud_pkg: shared audio-path types and widths for the player and recorder
package aud_pkg;
   localparam int AUD_SAMPLE_W = 16;
   localparam int AUD_ADDR_W   = 20;
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEND, S_HOLD, S_PAUSE} player_state_t;
endpackage

// File: rtl/aud_player_if.sv
// aud_player_if: control inputs, SRAM read port and DAC pins of the audio player
// master: player side (drives address, dacdat, playing, done)
// slave:  environment side (drives daclrck, start/pause/stop, mode, stop_address, sram_data)
interface aud_player_if #(
   parameter int SAMPLE_W = aud_pkg::AUD_SAMPLE_W,
   parameter int ADDR_W   = aud_pkg::AUD_ADDR_W
);
   logic                daclrck, start, pause, stop, fast, slow;
   logic [2:0]          speed;
   logic [ADDR_W-1:0]   stop_address, address;
   logic [SAMPLE_W-1:0] sram_data;
   logic                dacdat, playing, done;
   modport master (
      input  daclrck, start, pause, stop, fast, slow, speed, stop_address, sram_data,
      output address, dacdat, playing, done
   );
   modport slave (
      output daclrck, start, pause, stop, fast, slow, speed, stop_address, sram_data,
      input  address, dacdat, playing, done
   );
endinterface

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: DACLRCK edge detect plus MSB-first load/shift onto the DAC data pin
// Ports: i_clk BCLK, i_rst_n sync active-low reset, i_daclrck codec LRCK,
//        i_clr abort shifting, i_load load i_data, i_reload resend the last loaded word,
//        o_fall/o_rise LRCK edges this cycle, o_busy bits still pending, o_dacdat serial data
module i2s_tx_serializer #(
   parameter int SAMPLE_W = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_daclrck,
   input  logic                i_clr,
   input  logic                i_load,
   input  logic                i_reload,
   input  logic [SAMPLE_W-1:0] i_data,
   output logic                o_fall,
   output logic                o_rise,
   output logic                o_busy,
   output logic                o_dacdat
);
   localparam int CW = $clog2(SAMPLE_W);
   logic                lrc_q;
   logic [SAMPLE_W-1:0] sr_q, hold_q, word;
   logic [CW-1:0]       cnt_q;
   assign o_fall = lrc_q & ~i_daclrck;
   assign o_rise = ~lrc_q & i_daclrck;
   assign o_busy = cnt_q != '0;
   assign word   = i_load ? i_data : hold_q;
   // MSB goes straight to the output register on load, giving the one-BCLK I2S delay
   always_ff @(posedge i_clk)
      if (!i_rst_n) begin
         lrc_q    <= 1'b0;
         sr_q     <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         o_dacdat <= 1'b0;
      end else begin
         lrc_q <= i_daclrck;
         if (i_clr) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            o_dacdat <= 1'b0;
         end else if (i_load | i_reload) begin
            hold_q   <= word;
            sr_q     <= {word[SAMPLE_W-2:0], 1'b0};
            cnt_q    <= CW'(SAMPLE_W - 1);
            o_dacdat <= word[SAMPLE_W-1];
         end else begin
            sr_q     <= sr_q << 1;
            cnt_q    <= o_busy ? cnt_q - CW'(1) : cnt_q;
            o_dacdat <= o_busy & sr_q[SAMPLE_W-1];
         end
      end
endmodule

// File: rtl/aud_player.sv
// aud_player: I2S playback from audio SRAM with pause/stop, fast-forward and slow-motion
// Ports: i_clk codec BCLK, i_rst_n sync active-low reset,
//        bus (master) control inputs, SRAM read address/data, DAC data, playing/done status
module aud_player
   import aud_pkg::*;
#(
   parameter int SAMPLE_W = AUD_SAMPLE_W,
   parameter int ADDR_W   = AUD_ADDR_W
) (
   input  logic i_clk,
   input  logic i_rst_n,
   aud_player_if.master bus
);
   player_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        rep_q, rep_d;
   logic              last_q, last_d, done_q, done_d;
   logic              fall, rise, busy, load, reload, clr, dacdat;
   logic              slow, fast, exhausted;
   logic [ADDR_W:0]   step, sum;
   assign slow      = bus.slow & ~bus.fast;
   assign fast      = bus.fast & ~bus.slow;
   assign exhausted = ~slow | (rep_q >= bus.speed);
   assign step      = fast ? (ADDR_W+1)'(bus.speed) + (ADDR_W+1)'(1) : (ADDR_W+1)'(1);
   assign sum       = {1'b0, addr_q} + step;
   // o_address is a prefetch pointer: it names the word loaded at the next frame start,
   // so SRAM data settles for a whole frame; last_q marks that the word now playing ends playback
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rep_d   = rep_q;
      last_d  = last_q;
      done_d  = 1'b0;
      load    = 1'b0;
      reload  = 1'b0;
      clr     = 1'b0;
      if (bus.stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         addr_d  = '0;
         rep_d   = '0;
         last_d  = 1'b0;
         clr     = 1'b1;
      end else begin
         case (state_q)
            S_IDLE:  state_d = bus.start ? S_WAIT : S_IDLE;
            S_WAIT:  load = fall;
            S_SEND:  state_d = busy ? S_SEND : S_HOLD;
            S_HOLD: begin
               reload = rise;
               if (fall && bus.pause) state_d = S_PAUSE;
               else if (fall && last_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  addr_d  = '0;
                  rep_d   = '0;
                  last_d  = 1'b0;
               end else load = fall;
            end
            S_PAUSE: state_d = (bus.start && !bus.pause) ? S_WAIT : S_PAUSE;
            default: state_d = S_IDLE;
         endcase
         if (load) begin
            last_d = (addr_q == bus.stop_address) && exhausted;
            rep_d  = exhausted ? 3'd0 : rep_q + 3'd1;
            addr_d = !exhausted ? addr_q :
                     (sum > {1'b0, bus.stop_address}) ? bus.stop_address : sum[ADDR_W-1:0];
         end
         if (load | reload) state_d = S_SEND;
      end
   end
   always_ff @(posedge i_clk)
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rep_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rep_q   <= rep_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   i2s_tx_serializer #(.SAMPLE_W(SAMPLE_W)) u_ser (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_daclrck(bus.daclrck),
      .i_clr    (clr),
      .i_load   (load),
      .i_reload (reload),
      .i_data   (bus.sram_data),
      .o_fall   (fall),
      .o_rise   (rise),
      .o_busy   (busy),
      .o_dacdat (dacdat)
   );
   assign bus.address = addr_q;
   assign bus.dacdat  = dacdat;
   assign bus.playing = state_q inside {S_WAIT, S_SEND, S_HOLD};
   assign bus.done    = done_q;
endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: scoreboard bench for aud_player against a played-address reference model
module tb_aud_player;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mon_en = 1'b0;
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [15:0] mem [256];
   logic [16:0] exp_w[$];
   logic [19:0] exp_a[$];
   logic [19:0] last_addr = '0;
   logic [19:0] ea;
   logic [16:0] got, ew;

   aud_player_if bus();
   aud_player dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   assign bus.sram_data = mem[bus.address[7:0]];

   initial begin
      bus.daclrck = 1'b0;
      forever begin
         repeat (32) @(negedge clk);
         bus.daclrck = ~bus.daclrck;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   // address scoreboard: every change of o_address must match the next expected value
   always @(negedge clk)
      if (rst_n && bus.address !== last_addr) begin
         if (mon_en) begin
            checks++;
            if (exp_a.size() == 0) begin
               errors++;
               $display("FAIL addr_seq got=%0h exp=none", bus.address);
            end else begin
               ea = exp_a.pop_front();
               if (bus.address !== ea) begin
                  errors++;
                  $display("FAIL addr_seq got=%0h exp=%0h", bus.address, ea);
               end
            end
         end
         last_addr = bus.address;
      end

   // word scoreboard: after each LRCK edge where the player is sending, capture 16 bits and the trailing zero
   initial forever begin
      @(bus.daclrck);
      @(negedge clk);
      if (mon_en && bus.playing === 1'b1) begin
         got[16] = bus.dacdat;
         for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            got[i] = bus.dacdat;
         end
         checks++;
         if (exp_w.size() == 0) begin
            errors++;
            $display("FAIL word got=%0h exp=none", got);
         end else begin
            ew = exp_w.pop_front();
            if (got !== ew) begin
               errors++;
               $display("FAIL word got=%0h exp=%0h", got, ew);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, g, e);
      end
   endtask

   // reference: list the addresses played frame by frame, each word sent in both halves
   task automatic plan(input int mode, input int n, input int stop);
      int a, prev;
      int played[$];
      a = 0;
      forever begin
         if (mode == 2) repeat (n + 1) played.push_back(a);
         else played.push_back(a);
         if (a == stop) break;
         a = (mode == 1) ? ((a + n + 1 > stop) ? stop : a + n + 1) : a + 1;
      end
      prev = 0;
      foreach (played[i]) begin
         repeat (2) exp_w.push_back({mem[played[i]], 1'b0});
         if (played[i] != prev) exp_a.push_back(20'(played[i]));
         prev = played[i];
      end
      exp_a.push_back(20'd0);
   endtask

   task automatic kick();
      @(posedge bus.daclrck);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_addr(input string nm, input logic [19:0] a);
      int c = 0;
      while (bus.address !== a && c < 5000) begin
         @(negedge clk);
         c++;
      end
      chk(nm, bus.address, a);
   endtask

   task automatic set_mode(input int mode, input int n, input int stop);
      bus.fast = (mode == 1 || mode == 3);
      bus.slow = (mode == 2 || mode == 3);
      bus.speed = 3'(n);
      bus.stop_address = 20'(stop);
   endtask

   task automatic play(input int mode, input int n, input int stop, input bit do_pause);
      int d0, c;
      set_mode(mode, n, stop);
      plan(mode, n, stop);
      d0 = done_cnt;
      kick();
      if (do_pause) begin
         wait_addr("pause_reach", 20'd3);
         repeat (6) @(negedge clk);
         bus.pause = 1'b1;
         c = 0;
         while (bus.playing !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
         end
         chk("pause_entered", bus.playing, 1'b0);
         repeat (40) @(negedge clk);
         chk("pause_addr", bus.address, 20'd3);
         chk("pause_dat", bus.dacdat, 1'b0);
         bus.pause = 1'b0;
         kick();
      end
      c = 0;
      while (done_cnt == d0 && c < 10000) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
      chk("addr_idle", bus.address, 20'd0);
      chk("playing_idle", bus.playing, 1'b0);
      chk("words_left", exp_w.size(), 0);
      chk("addrs_left", exp_a.size(), 0);
      exp_w.delete();
      exp_a.delete();
   endtask

   initial begin
      int md, n, st, d0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop = 1'b0;
      set_mode(0, 0, 3);
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_addr", bus.address, 20'd0);
      chk("rst_dat", bus.dacdat, 1'b0);
      chk("rst_playing", bus.playing, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      mem[0] = 16'h8001;
      mem[1] = 16'h7FFE;
      mem[2] = 16'hAAAA;
      mem[3] = 16'h5555;
      play(0, 0, 3, 1'b0);
      play(1, 2, 7, 1'b0);
      play(2, 1, 1, 1'b0);
      play(0, 0, 5, 1'b1);
      for (int r = 0; r < 6; r++) begin
         md = int'($urandom_range(0, 3));
         n = int'($urandom_range(0, 7));
         st = int'($urandom_range(1, (md == 2) ? 3 : 6));
         for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
         play(md, n, st, 1'b0);
      end
      // stop mid-SEND together with start
      mon_en = 1'b0;
      set_mode(0, 0, 5);
      d0 = done_cnt;
      kick();
      wait_addr("stop_reach", 20'd1);
      repeat (6) @(negedge clk);
      bus.stop = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      bus.start = 1'b0;
      chk("stop_playing", bus.playing, 1'b0);
      chk("stop_addr", bus.address, 20'd0);
      chk("stop_dat", bus.dacdat, 1'b0);
      repeat (80) @(negedge clk);
      chk("stop_no_done", done_cnt - d0, 0);
      chk("stop_idle", bus.playing, 1'b0);
      // synchronous reset mid-frame
      kick();
      wait_addr("rst_reach", 20'd1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_sync_playing", bus.playing, 1'b1);
      chk("rst_sync_addr", bus.address, 20'd1);
      @(negedge clk);
      chk("rst2_addr", bus.address, 20'd0);
      chk("rst2_dat", bus.dacdat, 1'b0);
      chk("rst2_playing", bus.playing, 1'b0);
      chk("rst2_done", bus.done, 1'b0);
      rst_n = 1'b1;
      repeat (70) @(negedge clk);
      chk("rst2_stay_idle", bus.playing, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end
endmodule
